// File: rtl/alu_exec_sequencer.sv
// Multi-cycle execute controller placed in front of the ALU. Takes one decoded
// instruction per handshake, reads its operands, strobes the ALU, captures the
// result and flags, and writes the result back to the register file.
module alu_exec_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        alu_op,
  input  logic              use_imm,
  input  logic [IMM_W-1:0]  imm,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  input  logic [4:0]        shamt,
  input  logic              wb_en,
  input  logic              flag_en,
  output logic [REG_AW-1:0] rf_raddr1,
  output logic [REG_AW-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op_o,
  output logic [4:0]        alu_shamt,
  output logic              alu_ena,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_sign,
  input  logic              alu_carry,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              flag_zero,
  output logic              flag_sign,
  output logic              flag_carry,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {StIdle, StRead, StExec, StCapt, StWb} state_e;

  state_e state_q, state_d;

  logic [3:0]        op_q;
  logic              use_imm_q;
  logic [IMM_W-1:0]  imm_q;
  logic [REG_AW-1:0] rs_q, rt_q, rd_q;
  logic [4:0]        shamt_q;
  logic              wb_en_q, flag_en_q;
  logic [DATA_W-1:0] imm_ext;
  logic              accept;

  assign instr_ready = (state_q == StIdle);
  assign accept      = instr_valid && instr_ready;
  assign rf_raddr1   = rs_q;
  assign rf_raddr2   = rt_q;
  assign imm_ext     = {{(DATA_W - IMM_W){imm_q[IMM_W-1]}}, imm_q};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next state: only leaving idle depends on the handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRead;
      StRead:  state_d = StExec;
      StExec:  state_d = StCapt;
      StCapt:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Latch the instruction fields on acceptance; they stay valid until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      shamt_q   <= '0;
      wb_en_q   <= 1'b0;
      flag_en_q <= 1'b0;
    end else if (accept) begin
      op_q      <= alu_op;
      use_imm_q <= use_imm;
      imm_q     <= imm;
      rs_q      <= rs;
      rt_q      <= rt;
      rd_q      <= rd;
      shamt_q   <= shamt;
      wb_en_q   <= wb_en;
      flag_en_q <= flag_en;
    end
  end

  // Registered ALU-side and write-back outputs; operands, result and flags hold
  // between instructions so the ALU never sees a change while alu_ena is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op_o   <= '0;
      alu_shamt  <= '0;
      alu_ena    <= 1'b0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      flag_zero  <= 1'b0;
      flag_sign  <= 1'b0;
      flag_carry <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (state_q == StRead) begin
        alu_a     <= rf_rdata1;
        alu_b     <= use_imm_q ? imm_ext : rf_rdata2;
        alu_op_o  <= op_q;
        alu_shamt <= shamt_q;
      end
      if (state_q == StCapt) begin
        rf_wdata <= alu_result;
        rf_waddr <= rd_q;
        if (flag_en_q) begin
          flag_zero  <= alu_zero;
          flag_sign  <= alu_sign;
          flag_carry <= alu_carry;
        end
      end
      alu_ena <= (state_d == StExec);
      // Register 0 is hard-wired; never write it.
      rf_we   <= (state_d == StWb) && wb_en_q && (rd_q != '0);
      done    <= (state_d == StWb);
      busy    <= (state_d != StIdle);
    end
  end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench for alu_exec_sequencer with a small register file and ALU model.
module tb_alu_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  alu_op = '0;
  logic        use_imm = 1'b0;
  logic [15:0] imm = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic [4:0]  shamt = '0;
  logic        wb_en = 1'b0, flag_en = 1'b0;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op_o;
  logic [4:0]  alu_shamt;
  logic        alu_ena;
  logic [31:0] alu_result = '0;
  logic        alu_zero = 1'b0, alu_sign = 1'b0, alu_carry = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        flag_zero, flag_sign, flag_carry;
  logic        busy, done;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] rf [32];

  // Per-instruction traces, bit k = cycle k after the acceptance edge.
  logic [3:0]  ena_tr, done_tr, we_tr, rdy_tr, busy_tr;
  logic [31:0] a_cap, b_cap, wdata_cap;
  logic [4:0]  waddr_cap, shamt_cap;
  logic [3:0]  op_cap;
  logic        idle_rdy, idle_busy;

  alu_exec_sequencer #(.DATA_W(32), .REG_AW(5), .IMM_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_op      (alu_op),
    .use_imm     (use_imm),
    .imm         (imm),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .wb_en       (wb_en),
    .flag_en     (flag_en),
    .rf_raddr1   (rf_raddr1),
    .rf_raddr2   (rf_raddr2),
    .rf_rdata1   (rf_rdata1),
    .rf_rdata2   (rf_rdata2),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op_o    (alu_op_o),
    .alu_shamt   (alu_shamt),
    .alu_ena     (alu_ena),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .alu_sign    (alu_sign),
    .alu_carry   (alu_carry),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .flag_zero   (flag_zero),
    .flag_sign   (flag_sign),
    .flag_carry  (flag_carry),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  // Register-file write port.
  always @(posedge clk) begin
    if (!rst && rf_we) rf[rf_waddr] <= rf_wdata;
  end

  // ALU model: evaluates on the rising edge of alu_ena; op 1 is add.
  always @(posedge alu_ena) begin
    logic [32:0] sum;
    if (alu_op_o == 4'b0001) sum = {1'b0, alu_a} + {1'b0, alu_b};
    else                     sum = {1'b0, alu_a ^ alu_b};
    alu_result = sum[31:0];
    alu_carry  = sum[32];
    alu_zero   = (sum[31:0] == 32'd0);
    alu_sign   = sum[31];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic ui, input logic [15:0] im,
                       input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                       input logic we, input logic fe);
    alu_op = op; use_imm = ui; imm = im; rs = s; rt = t; rd = d;
    wb_en = we; flag_en = fe; shamt = 5'd9;
  endtask

  // Waits (bounded) for ready at a negedge, so the next posedge accepts.
  task automatic wait_ready();
    int waited = 0;
    while (!instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!instr_ready) check_eq("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_instr(input logic [3:0] op, input logic ui, input logic [15:0] im,
                           input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                           input logic we, input logic fe);
    drive(op, ui, im, s, t, d, we, fe);
    instr_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1 instr_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ena_tr[k]  = alu_ena;
      done_tr[k] = done;
      we_tr[k]   = rf_we;
      rdy_tr[k]  = instr_ready;
      busy_tr[k] = busy;
      if (k == 1) begin
        a_cap = alu_a; b_cap = alu_b; op_cap = alu_op_o; shamt_cap = alu_shamt;
      end
      if (k == 3) begin
        waddr_cap = rf_waddr; wdata_cap = rf_wdata;
      end
    end
    @(negedge clk);
    idle_rdy  = instr_ready;
    idle_busy = busy;
  endtask

  initial begin
    logic [9:0] rdy10, done10;
    logic [31:0] wd_first, wd_second;
    logic        bad_pulse;

    for (int i = 0; i < 32; i++) rf[i] = '0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_outs", {alu_a | alu_b | rf_wdata}, 32'd0);
    check_eq("rst_ctl", {25'd0, alu_ena, rf_we, busy, done, flag_zero, flag_sign, flag_carry},
             32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", {31'd0, instr_ready}, 32'd1);

    // 1: 5 + 7 -> r3.
    rf[1] = 32'd5; rf[2] = 32'd7;
    run_instr(4'b0001, 1'b0, 16'h0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    check_eq("s1_ena_trace", {28'd0, ena_tr}, 32'b0010);
    check_eq("s1_done_trace", {28'd0, done_tr}, 32'b1000);
    check_eq("s1_we_trace", {28'd0, we_tr}, 32'b1000);
    check_eq("s1_ready_trace", {28'd0, rdy_tr}, 32'b0000);
    check_eq("s1_busy_trace", {28'd0, busy_tr}, 32'b1111);
    check_eq("s1_operands", {a_cap[15:0], b_cap[15:0]}, {16'd5, 16'd7});
    check_eq("s1_op_shamt", {23'd0, op_cap, shamt_cap}, {23'd0, 4'b0001, 5'd9});
    check_eq("s1_waddr", {27'd0, waddr_cap}, 32'd3);
    check_eq("s1_wdata", wdata_cap, 32'd12);
    check_eq("s1_flags", {29'd0, flag_zero, flag_sign, flag_carry}, 32'b000);
    check_eq("s1_idle", {30'd0, idle_rdy, idle_busy}, 32'b10);
    check_eq("s1_rf3", rf[3], 32'd12);

    // 2: 0xFFFFFFFF + 1 -> r4, wraps to zero with carry.
    rf[1] = 32'hFFFF_FFFF; rf[2] = 32'd1;
    run_instr(4'b0001, 1'b0, 16'h0, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1);
    check_eq("s2_wdata", wdata_cap, 32'd0);
    check_eq("s2_flags", {29'd0, flag_zero, flag_sign, flag_carry}, 32'b101);

    // 3: 1 + sext(0xFFFF); r[rt] is ignored.
    rf[1] = 32'd1; rf[2] = 32'h1234_5678;
    run_instr(4'b0001, 1'b1, 16'hFFFF, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
    check_eq("s3_alu_b", b_cap, 32'hFFFF_FFFF);
    check_eq("s3_wdata", wdata_cap, 32'd0);
    check_eq("s3_flags", {29'd0, flag_zero, flag_sign, flag_carry}, 32'b101);

    // 4a: rd = 0, flags still update (cleared by 5 + 7).
    rf[1] = 32'd5; rf[2] = 32'd7;
    run_instr(4'b0001, 1'b0, 16'h0, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1);
    check_eq("s4a_we_trace", {28'd0, we_tr}, 32'b0000);
    check_eq("s4a_done_trace", {28'd0, done_tr}, 32'b1000);
    check_eq("s4a_flags", {29'd0, flag_zero, flag_sign, flag_carry}, 32'b000);
    check_eq("s4a_rf0", rf[0], 32'd0);

    // 4b: flag_en = 0 with a result that would set Z and C.
    rf[1] = 32'hFFFF_FFFF; rf[2] = 32'd1;
    run_instr(4'b0001, 1'b0, 16'h0, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
    check_eq("s4b_we_trace", {28'd0, we_tr}, 32'b0000);
    check_eq("s4b_flags", {29'd0, flag_zero, flag_sign, flag_carry}, 32'b000);

    // 5: valid held high over two back-to-back instructions.
    rf[1] = 32'd10; rf[2] = 32'd20;
    drive(4'b0001, 1'b0, 16'h0, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
    instr_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1 drive(4'b0001, 1'b1, 16'h8000, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1);
    wd_first = '0; wd_second = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rdy10[k]  = instr_ready;
      done10[k] = done;
      if (k == 3) wd_first = rf_wdata;
      if (k == 5) instr_valid = 1'b0;
      if (k == 8) wd_second = rf_wdata;
    end
    check_eq("s5_ready_trace", {22'd0, rdy10}, {22'd0, 10'b1000010000});
    check_eq("s5_done_trace", {22'd0, done10}, {22'd0, 10'b0100001000});
    check_eq("s5_wdata1", wd_first, 32'd30);
    check_eq("s5_wdata2", wd_second, 32'hFFFF_800A);
    check_eq("s5_flags", {29'd0, flag_zero, flag_sign, flag_carry}, 32'b010);
    check_eq("s5_rf5", rf[5], 32'd30);

    // 6: reset during EXEC aborts the instruction.
    rf[1] = 32'd5; rf[2] = 32'd7; rf[3] = 32'hDEAD_BEEF;
    drive(4'b0001, 1'b0, 16'h0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    instr_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("s6_ena_before", {31'd0, alu_ena}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("s6_rst_ctl", {28'd0, alu_ena, busy, done, rf_we}, 32'd0);
    check_eq("s6_rst_flags", {29'd0, flag_zero, flag_sign, flag_carry}, 32'b000);
    bad_pulse = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bad_pulse |= done | rf_we;
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bad_pulse |= done | rf_we;
    end
    check_eq("s6_no_wb", {31'd0, bad_pulse}, 32'd0);
    check_eq("s6_rf3_kept", rf[3], 32'hDEAD_BEEF);
    rf[1] = 32'd2; rf[2] = 32'd3;
    run_instr(4'b0001, 1'b0, 16'h0, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1);
    check_eq("s6_done_trace", {28'd0, done_tr}, 32'b1000);
    check_eq("s6_wdata", wdata_cap, 32'd5);
    check_eq("s6_rf8", rf[8], 32'd5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
